mc_controller: RTL and testbench

//  Multicycle control FSM for the RV32I datapath (PC/IR/OldPC/ALUOut/Data regs, shared I/D memory port).

---
 rtl/mc_ctrl_pkg.sv | 69 ++++++
 rtl/mc_alu_dec.sv | 39 +++
 rtl/mc_controller.sv | 251 +++++++++++++++++++++++++
 tb/tb_mc_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the RV32I multicycle controller.
//   FSM state codes (4-bit, exported on state_o), opcode constants, and the
//   select/ALU encodings driven onto the datapath.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRWB   = 4'd12,
    S_UTYPE    = 4'd13,
    S_HALT     = 4'd14
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  // Coarse ALU intent from the FSM; FUNCT defers to funct3/funct7b5.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

endpackage

// File: rtl/mc_alu_dec.sv
// mc_alu_dec: combinational ALU control decode.
//   i_op      opcode (distinguishes R-type SUB from I-type ADDI)
//   i_funct3  IR[14:12]
//   i_f7b5    IR[30]
//   i_aluop   coarse intent from the FSM (ADD / SUB / FUNCT)
//   o_alu_ctl ALUControl encoding
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_f7b5,
  input  logic [1:0] i_aluop,
  output logic [3:0] o_alu_ctl
);

  always_comb begin
    o_alu_ctl = ALU_ADD;
    case (i_aluop)
      ALUOP_SUB:   o_alu_ctl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          // IR[30] is an immediate bit for ADDI, so SUB only for R-type.
          3'b000:  o_alu_ctl = (i_op == OP_R && i_f7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  o_alu_ctl = ALU_SLL;
          3'b010:  o_alu_ctl = ALU_SLT;
          3'b011:  o_alu_ctl = ALU_SLTU;
          3'b100:  o_alu_ctl = ALU_XOR;
          // For shifts IR[30] selects arithmetic in both R and I forms.
          3'b101:  o_alu_ctl = i_f7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  o_alu_ctl = ALU_OR;
          default: o_alu_ctl = ALU_AND;
        endcase
      end
      default:     o_alu_ctl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle control FSM for the RV32I datapath.
//   Sequences fetch/decode/execute/mem/writeback, drives datapath selects
//   and strobes, stalls on mem_ready, and halts on a memory wait timeout.
// Ports:
//   clk, reset (async, active-low)
//   op, funct3, funct7b5      instruction fields from IR
//   Zero, LT, LTU             ALU compare flags (used in BRANCH)
//   mem_ready                 memory completes current request
//   PCWrite, IRWrite, RegWrite, MemRead, MemWrite  strobes
//   AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl  selects
//   mem_err (sticky timeout), illegal (sticky bad opcode), state_o (debug)
// Build option: MC_CTRL_ILLEGAL_TRAP_EN makes an unsupported opcode set
//   illegal and halt; otherwise it runs as a NOP and illegal is tied 0.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMR_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       LT,
  input  logic       LTU,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output logic [3:0] ALUControl,
  output logic       mem_err,
  output logic       illegal,
  output logic [3:0] state_o
);

  localparam logic [TMR_W-1:0] LAST_WAIT =
    (MEM_TIMEOUT == 0) ? '0 : TMR_W'(MEM_TIMEOUT - 1);

  state_e           r_state, w_next;
  logic [TMR_W-1:0] r_cnt;
  logic             r_mem_err;
  logic             w_pcwrite, w_irwrite, w_regwrite, w_memread, w_memwrite;
  logic [1:0]       w_aluop;
  logic             w_taken, w_expired, w_timeout, w_mem_state;

  mc_alu_dec u_alu_dec (
    .i_op      (op),
    .i_funct3  (funct3),
    .i_f7b5    (funct7b5),
    .i_aluop   (w_aluop),
    .o_alu_ctl (ALUControl)
  );

  always_comb begin
    case (funct3)
      3'b000:  w_taken = Zero;
      3'b001:  w_taken = ~Zero;
      3'b100:  w_taken = LT;
      3'b101:  w_taken = ~LT;
      3'b110:  w_taken = LTU;
      3'b111:  w_taken = ~LTU;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                       (r_state == S_MEMWRITE);
  // A ready on the final allowed cycle completes normally.
  assign w_expired = (MEM_TIMEOUT != 0) && (r_cnt == LAST_WAIT) && !mem_ready;

  always_comb begin
    w_next     = r_state;
    w_pcwrite  = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_timeout  = 1'b0;
    w_aluop    = ALUOP_ADD;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ImmSrc     = IMM_I;
    case (r_state)
      S_FETCH: begin
        w_memread = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        if (mem_ready) begin
          w_irwrite = 1'b1;
          w_pcwrite = 1'b1;
          w_next    = S_DECODE;
        end else if (w_expired) begin
          w_timeout = 1'b1;
          w_next    = S_HALT;
        end
      end
      S_DECODE: begin
        // ALUOut <= OldPC + imm: branch/jal target ready for later states.
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R:              w_next = S_EXECR;
          OP_I:              w_next = S_EXECI;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR;
          OP_LUI, OP_AUIPC:  w_next = S_UTYPE;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
          default:           w_next = S_HALT;
`else
          default:           w_next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
        w_next  = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc    = 1'b1;
        w_memread = 1'b1;
        if (mem_ready)      w_next = S_MEMWB;
        else if (w_expired) begin w_timeout = 1'b1; w_next = S_HALT; end
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        w_memwrite = 1'b1;
        if (mem_ready)      w_next = S_FETCH;
        else if (w_expired) begin w_timeout = 1'b1; w_next = S_HALT; end
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        w_aluop = ALUOP_FUNCT;
        w_next  = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_I;
        w_aluop = ALUOP_FUNCT;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc  = RES_ALUOUT;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        w_aluop   = ALUOP_SUB;
        ResultSrc = RES_ALUOUT;
        w_pcwrite = w_taken;
        w_next    = S_FETCH;
      end
      S_JAL: begin
        // PC <= ALUOut (target); ALU forms OldPC+4 as the link for ALUWB.
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALUOUT;
        w_pcwrite = 1'b1;
        w_next    = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_IMM;
        ImmSrc    = IMM_I;
        ResultSrc = RES_ALURES;
        w_pcwrite = 1'b1;
        w_next    = S_JALRWB;
      end
      S_JALRWB: begin
        // rs1 was consumed last cycle, so rd==rs1 is harmless here.
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURES;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_UTYPE: begin
        ImmSrc     = IMM_U;
        w_regwrite = 1'b1;
        if (op == OP_LUI) begin
          ResultSrc = RES_IMM;
        end else begin
          ALUSrcA   = SRCA_OLDPC;
          ALUSrcB   = SRCB_IMM;
          ResultSrc = RES_ALURES;
        end
        w_next = S_FETCH;
      end
      default: w_next = S_HALT;   // HALT and unused codes: park
    endcase
  end

  // Strobes are killed combinationally so reset takes effect immediately.
  assign PCWrite  = w_pcwrite  & reset;
  assign IRWrite  = w_irwrite  & reset;
  assign RegWrite = w_regwrite & reset;
  assign MemRead  = w_memread  & reset;
  assign MemWrite = w_memwrite & reset;
  assign mem_err  = r_mem_err;
  assign state_o  = r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_cnt     <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_timeout) r_mem_err <= 1'b1;
      // Any state change clears, so each memory state starts a fresh wait.
      if (w_next != r_state)                          r_cnt <= '0;
      else if (w_mem_state && !mem_ready && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic r_illegal;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                        r_illegal <= 1'b0;
    else if (r_state == S_DECODE && w_next == S_HALT) r_illegal <= 1'b1;
  end
  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed stimulus with a per-cycle expectation queue.
//   Stimulus sets inputs just after each rising edge and queues the
//   hand-computed outputs for that cycle; the monitor pops and compares at
//   the falling edge. Fields given as -1 are not compared.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0, LT = 1'b0, LTU = 1'b0;
  logic       mem_ready = 1'b1;
  logic       PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  logic [3:0] ALUControl, state_o;
  logic       mem_err, illegal;

  mc_controller #(.MEM_TIMEOUT(4), .TMR_W(8)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .LT(LT), .LTU(LTU), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .mem_err(mem_err), .illegal(illegal),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  // bits: [24:21] state [20:16] {PCW,IRW,RegW,MemR,MemW} [15] AdrSrc
  //       [14:13] Res [12:11] A [10:9] B [8:6] Imm [5:2] ALU [1] err [0] ill
  typedef struct { string nm; logic [24:0] v; logic [24:0] m; } exp_t;
  exp_t q[$];
  int   n_chk = 0, n_pass = 0;
  logic exp_err = 1'b0, exp_ill = 1'b0;

  task automatic cyc(input string nm, input int st, input int stb, input int adr,
                     input int res, input int a, input int b, input int imm,
                     input int alu);
    exp_t e;
    e.nm = nm; e.v = '0; e.m = '0;
    if (st  >= 0) begin e.v[24:21] = st[3:0];  e.m[24:21] = '1; end
    if (stb >= 0) begin e.v[20:16] = stb[4:0]; e.m[20:16] = '1; end
    if (adr >= 0) begin e.v[15]    = adr[0];   e.m[15]    = 1'b1; end
    if (res >= 0) begin e.v[14:13] = res[1:0]; e.m[14:13] = '1; end
    if (a   >= 0) begin e.v[12:11] = a[1:0];   e.m[12:11] = '1; end
    if (b   >= 0) begin e.v[10:9]  = b[1:0];   e.m[10:9]  = '1; end
    if (imm >= 0) begin e.v[8:6]   = imm[2:0]; e.m[8:6]   = '1; end
    if (alu >= 0) begin e.v[5:2]   = alu[3:0]; e.m[5:2]   = '1; end
    e.v[1] = exp_err; e.v[0] = exp_ill; e.m[1:0] = 2'b11;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [24:0] obs;
      e = q.pop_front();
      obs = {state_o, PCWrite, IRWrite, RegWrite, MemRead, MemWrite, AdrSrc,
             ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, mem_err, illegal};
      n_chk++;
      if ((obs & e.m) == (e.v & e.m)) n_pass++;
      else $display("FAIL %s: got %h expected %h (mask %h)", e.nm, obs & e.m,
                    e.v & e.m, e.m);
    end
  end

  task automatic set_ir(input logic [31:0] ir);
    op = ir[6:0]; funct3 = ir[14:12]; funct7b5 = ir[30];
  endtask

  task automatic fetch_ok(input string nm);
    mem_ready = 1'b1;
    cyc(nm, 0, 5'b11010, 0, 2, 0, 2, -1, 0);
  endtask

  task automatic rst_cyc(input string nm);
    reset = 1'b0; exp_err = 1'b0; exp_ill = 1'b0;
    cyc(nm, 0, 5'b00000, 0, 2, 0, 2, -1, 0);
    reset = 1'b1;
  endtask

  initial begin
    @(posedge clk); #1;
    mem_ready = 1'b1;
    rst_cyc("reset_state");

    // add x3,x1,x2
    set_ir(32'h002081B3);
    fetch_ok("add_fetch");
    cyc("add_decode", 1, 5'b00000, -1, -1, 1, 1, 2, 0);
    cyc("add_execr",  6, 5'b00000, -1, -1, 2, 0, -1, 0);
    cyc("add_aluwb",  8, 5'b00100, -1, 0, -1, -1, -1, -1);
    // sub x3,x1,x2
    set_ir(32'h402081B3);
    fetch_ok("sub_fetch");
    cyc("sub_decode", 1, 5'b00000, -1, -1, 1, 1, 2, 0);
    cyc("sub_execr",  6, 5'b00000, -1, -1, 2, 0, -1, 1);
    cyc("sub_aluwb",  8, 5'b00100, -1, 0, -1, -1, -1, -1);
    // addi x1,x0,-1 : IR[30]=1 must not turn ADD into SUB
    set_ir(32'hFFF00093);
    fetch_ok("addi_fetch");
    cyc("addi_decode", 1, 5'b00000, -1, -1, 1, 1, 2, 0);
    cyc("addi_execi",  7, 5'b00000, -1, -1, 2, 1, 0, 0);
    cyc("addi_aluwb",  8, 5'b00100, -1, 0, -1, -1, -1, -1);
    // srai x1,x1,3
    set_ir(32'h4030D093);
    fetch_ok("srai_fetch");
    cyc("srai_decode", 1, 5'b00000, -1, -1, 1, 1, 2, 0);
    cyc("srai_execi",  7, 5'b00000, -1, -1, 2, 1, 0, 9);
    cyc("srai_aluwb",  8, 5'b00100, -1, 0, -1, -1, -1, -1);

    // lw x5,0(x1), 3 stall cycles; ready arrives on the last allowed cycle
    set_ir(32'h0000A283);
    fetch_ok("lw_fetch");
    cyc("lw_decode", 1, 5'b00000, -1, -1, 1, 1, 2, 0);
    cyc("lw_memadr", 2, 5'b00000, -1, -1, 2, 1, 0, 0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lw_memread_wait", 3, 5'b00010, 1, -1, -1, -1, -1, -1);
    mem_ready = 1'b1;
    cyc("lw_memread_done", 3, 5'b00010, 1, -1, -1, -1, -1, -1);
    cyc("lw_memwb", 4, 5'b00100, -1, 1, -1, -1, -1, -1);

    // sw x5,0(x1)
    set_ir(32'h0050A023);
    fetch_ok("sw_fetch");
    cyc("sw_decode",   1, 5'b00000, -1, -1, 1, 1, 2, 0);
    cyc("sw_memadr",   2, 5'b00000, -1, -1, 2, 1, 1, 0);
    cyc("sw_memwrite", 5, 5'b00001, 1, -1, -1, -1, -1, -1);

    // branches
    set_ir(32'h00208063); Zero = 1'b1;
    fetch_ok("beq_fetch");
    cyc("beq_decode", 1, 5'b00000, -1, -1, 1, 1, 2, 0);
    cyc("beq_taken",  9, 5'b10000, -1, 0, 2, 0, -1, 1);
    set_ir(32'h00209063);
    fetch_ok("bne_fetch");
    cyc("bne_decode",    1, 5'b00000, -1, -1, 1, 1, 2, 0);
    cyc("bne_not_taken", 9, 5'b00000, -1, 0, 2, 0, -1, 1);
    set_ir(32'h0020E063); Zero = 1'b0; LTU = 1'b1;
    fetch_ok("bltu_fetch");
    cyc("bltu_decode", 1, 5'b00000, -1, -1, 1, 1, 2, 0);
    cyc("bltu_taken",  9, 5'b10000, -1, 0, 2, 0, -1, 1);
    set_ir(32'h0020D063); LT = 1'b1; LTU = 1'b0;
    fetch_ok("bge_fetch");
    cyc("bge_decode",    1, 5'b00000, -1, -1, 1, 1, 2, 0);
    cyc("bge_not_taken", 9, 5'b00000, -1, 0, 2, 0, -1, 1);
    LT = 1'b0;

    // jal x1,0
    set_ir(32'h000000EF);
    fetch_ok("jal_fetch");
    cyc("jal_decode", 1, 5'b00000, -1, -1, 1, 1, 3, 0);
    cyc("jal_jump",   10, 5'b10000, -1, 0, 1, 2, -1, 0);
    cyc("jal_link",   8, 5'b00100, -1, 0, -1, -1, -1, -1);
    // jalr x1,0(x1)
    set_ir(32'h000080E7);
    fetch_ok("jalr_fetch");
    cyc("jalr_decode", 1, 5'b00000, -1, -1, 1, 1, 2, 0);
    cyc("jalr_jump",   11, 5'b10000, -1, 2, 2, 1, 0, 0);
    cyc("jalr_link",   12, 5'b00100, -1, 2, 1, 2, -1, 0);
    // lui x5,0x12345 / auipc x5,0
    set_ir(32'h123452B7);
    fetch_ok("lui_fetch");
    cyc("lui_decode", 1, 5'b00000, -1, -1, 1, 1, 2, 0);
    cyc("lui_utype",  13, 5'b00100, -1, 3, -1, -1, 4, -1);
    set_ir(32'h00000297);
    fetch_ok("auipc_fetch");
    cyc("auipc_decode", 1, 5'b00000, -1, -1, 1, 1, 2, 0);
    cyc("auipc_utype",  13, 5'b00100, -1, 2, 1, 1, 4, 0);

    // unsupported opcode
    set_ir(32'h0000007F);
    fetch_ok("bad_fetch");
    cyc("bad_decode", 1, 5'b00000, -1, -1, 1, 1, 2, 0);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    exp_ill = 1'b1;
    cyc("bad_halt", 14, 5'b00000, -1, -1, -1, -1, -1, -1);
`else
    cyc("bad_nop_fetch", 0, 5'b11010, 0, 2, 0, 2, -1, 0);
`endif
    rst_cyc("bad_reset");

    // reset while a store is waiting: MemWrite must drop at once
    set_ir(32'h0050A023);
    fetch_ok("sw2_fetch");
    cyc("sw2_decode", 1, 5'b00000, -1, -1, 1, 1, 2, 0);
    cyc("sw2_memadr", 2, 5'b00000, -1, -1, 2, 1, 1, 0);
    mem_ready = 1'b0;
    cyc("sw2_memwrite_wait", 5, 5'b00001, 1, -1, -1, -1, -1, -1);
    rst_cyc("sw2_async_reset");

    // fetch timeout: 4 waits then HALT with mem_err, no strobes
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc("to_fetch_wait", 0, 5'b00010, 0, 2, 0, 2, -1, 0);
    exp_err = 1'b1;
    cyc("to_halt", 14, 5'b00000, -1, -1, -1, -1, -1, -1);
    mem_ready = 1'b1;
    cyc("to_halt_ready", 14, 5'b00000, -1, -1, -1, -1, -1, -1);
    rst_cyc("to_reset_clears");
    fetch_ok("post_reset_fetch");

    @(negedge clk); #1;
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL queue_drain: %0d left, expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
